// File: rtl/ce.sv
// ce: pipelined signed multiply-accumulate over a CL_IN x KERNEL x KERNEL window with shift, optional ReLU and saturation
module ce #(
    parameter int CL_IN  = 4,
    parameter int KERNEL = 3,
    parameter int RELU   = 1,
    parameter int N      = 4,
    parameter int M      = 4,
    parameter int SR     = 2,
    localparam int E     = (KERNEL == 3) ? 3 : (KERNEL == 5) ? 4 : (KERNEL == 7) ? 5 : 1,
    localparam int W     = N + M + E + 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [CL_IN*KERNEL*KERNEL*N-1:0]  data2conv,
    input  logic                              en_in,
    input  logic [CL_IN*KERNEL*KERNEL*M-1:0]  w,
    output logic signed [W-1:0]               d_out,
    output logic                              en_out
);
    localparam int P  = CL_IN * KERNEL * KERNEL;
    localparam int PW = N + M;
    // sum width covers P products of magnitude at most 2^(PW-2) with margin
    localparam int SW = PW + $clog2(P) + 1;
    // one extra bit so the saturation bounds always fit as positive/negative values
    localparam int CW = (SW > W ? SW : W) + 1;
    localparam logic signed [CW-1:0] MAXV = {{(CW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [CW-1:0] MINV = {{(CW-W+1){1'b1}}, {(W-1){1'b0}}};

    logic [2:0]             v_q;
    logic signed [PW-1:0]   prod_q [P];
    logic signed [SW-1:0]   sum_d, sum_q, sh;
    logic signed [CW-1:0]   ext, rl;
    logic signed [W-1:0]    d_d, d_out_q;

    // valid bit travelling alongside the three data stages
    always_ff @(posedge clk) begin
        v_q <= rst ? '0 : {v_q[1:0], en_in};
    end

    // stage 1: full-precision element-wise products, loaded only for valid samples
    always_ff @(posedge clk) begin
        if (en_in)
            for (int i = 0; i < P; i++)
                prod_q[i] <= PW'($signed(data2conv[i*N +: N])) * PW'($signed(w[i*M +: M]));
    end

    // full-precision sum of all products
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < P; i++)
            sum_d = sum_d + SW'(prod_q[i]);
    end

    // stage 2: register the sum
    always_ff @(posedge clk) begin
        if (v_q[0])
            sum_q <= sum_d;
    end

    // floor shift, optional ReLU, then clamp to the output range
    always_comb begin
        sh  = sum_q >>> SR;
        ext = CW'(sh);
        rl  = (RELU != 0 && ext[CW-1]) ? '0 : ext;
        d_d = (rl > MAXV) ? MAXV[W-1:0] : (rl < MINV) ? MINV[W-1:0] : rl[W-1:0];
    end

    // stage 3: output register holds its value between valid results
    always_ff @(posedge clk) begin
        if (rst)
            d_out_q <= '0;
        else if (v_q[1])
            d_out_q <= d_d;
    end

    assign d_out  = d_out_q;
    assign en_out = v_q[2];
endmodule

// File: tb/tb_ce.sv
// tb_ce: directed checks of ce against a queue-based arithmetic model, three parameterisations
module tb_ce;
    localparam int D  = 144;
    localparam int DB = 2304;

    logic clk = 0, rst = 1, en_in = 0;
    logic [D-1:0] d = '0, wt = '0;
    logic [DB-1:0] db = {576{4'b1000}};
    logic signed [13:0] d1, d0, db_o;
    logic e1o, e0o, ebo;

    always #5 clk = ~clk;

    ce u_r (.clk(clk), .rst(rst), .data2conv(d), .en_in(en_in), .w(wt), .d_out(d1), .en_out(e1o));
    ce #(.RELU(0)) u_n (.clk(clk), .rst(rst), .data2conv(d), .en_in(en_in), .w(wt), .d_out(d0), .en_out(e0o));
    ce #(.CL_IN(64)) u_b (.clk(clk), .rst(rst), .data2conv(db), .en_in(en_in), .w(db), .d_out(db_o), .en_out(ebo));

    typedef struct { int due; longint v1; longint v0; } item_t;
    item_t q[$];
    int cyc = 0, total = 0, bad = 0;
    bit ev = 0, seen = 0, armed = 0;
    longint x1 = 0, x0 = 0;

    task automatic chk(string nm, longint act, longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    function automatic logic [D-1:0] rep(logic [3:0] v);
        return {36{v}};
    endfunction

    function automatic logic [D-1:0] rnd();
        logic [159:0] t = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return t[D-1:0];
    endfunction

    // dot product, floor division by 4, optional ReLU, clamp to 14-bit signed
    function automatic longint model(logic [D-1:0] dv, logic [D-1:0] wv, bit relu);
        longint s = 0;
        for (int i = 0; i < 36; i++)
            s += longint'($signed(dv[i*4 +: 4])) * longint'($signed(wv[i*4 +: 4]));
        s = (s < 0) ? -((-s + 3) / 4) : s / 4;
        if (relu && s < 0) s = 0;
        if (s > 8191) s = 8191;
        if (s < -8192) s = -8192;
        return s;
    endfunction

    // inputs driven in cycle cyc are expected at the outputs in cycle cyc+3
    task automatic step(bit r, bit e, logic [D-1:0] dv, logic [D-1:0] wv);
        @(negedge clk);
        rst = r; en_in = e; d = dv; wt = wv;
        @(posedge clk);
        if (r) begin
            q.delete(); ev = 0; seen = 0; x1 = 0; x0 = 0;
        end else begin
            ev = 0;
            if (q.size() > 0 && q[0].due == cyc + 1) begin
                item_t it = q.pop_front();
                ev = 1; seen = 1; x1 = it.v1; x0 = it.v0;
            end
            if (e) q.push_back(item_t'{cyc + 3, model(dv, wv, 1), model(dv, wv, 0)});
        end
        cyc++;
        armed = 1;
    endtask

    task automatic hold(logic [D-1:0] dv, logic [D-1:0] wv, int n);
        repeat (n) step(0, 1, dv, wv);
    endtask

    always @(negedge clk) begin
        if (armed) begin
            chk("en_out", longint'(e1o), longint'(ev));
            chk("d_out", d1, x1);
            chk("en_out_norelu", longint'(e0o), longint'(ev));
            chk("d_out_norelu", d0, x0);
            chk("en_out_big", longint'(ebo), longint'(ev));
            chk("d_out_big", db_o, seen ? 8191 : 0);
        end
    end

    initial begin
        logic [D-1:0] fv;
        chk("model_ones", model(rep(4'hF), rep(4'hF), 1), 9);
        chk("model_relu", model(rep(4'h1), rep(4'hF), 1), 0);
        chk("model_norelu", model(rep(4'h1), rep(4'hF), 0), -9);
        chk("model_min", model(rep(4'h8), rep(4'h8), 1), 576);
        fv = rep(4'h0);
        fv[3:0] = 4'hF;
        chk("model_floor", model(fv, rep(4'h1), 0), -1);

        step(1, 0, '0, '0);
        step(1, 1, rep(4'hF), rep(4'hF));
        #1 chk("reset_d", d1, 0);
        chk("reset_en", longint'(e1o), 0);

        hold(rep(4'hF), rep(4'hF), 5);
        #1 chk("ones_d", d1, 9);
        chk("ones_en", longint'(e1o), 1);
        hold(rep(4'h1), rep(4'hF), 4);
        #1 chk("relu_d", d1, 0);
        chk("norelu_d", d0, -9);
        hold(rep(4'h8), rep(4'h8), 4);
        #1 chk("min_d", d1, 576);
        chk("big_sat", db_o, 8191);
        hold(fv, rep(4'h1), 4);
        #1 chk("floor_d", d0, -1);
        chk("floor_relu_d", d1, 0);

        step(0, 1, rep(4'h2), rep(4'h3));
        step(0, 0, rep(4'h7), rep(4'h7));
        step(0, 1, rep(4'h1), rep(4'h5));
        #1 chk("pat0_en", longint'(e1o), 1);
        chk("pat0_d", d1, 54);
        step(0, 1, rep(4'hD), rep(4'h5));
        #1 chk("pat1_en", longint'(e1o), 0);
        chk("pat1_hold", d1, 54);
        step(0, 0, '0, '0);
        #1 chk("pat2_en", longint'(e1o), 1);
        chk("pat2_d", d1, 45);
        step(0, 0, '0, '0);
        #1 chk("pat3_en", longint'(e0o), 1);
        chk("pat3_d", d0, -135);

        repeat (8) step(0, 1'($urandom_range(0, 1)), rnd(), rnd());
        repeat (4) step(0, 0, '0, '0);

        step(0, 1, rep(4'h2), rep(4'h2));
        step(0, 1, rep(4'h3), rep(4'h3));
        step(1, 1, rep(4'hF), rep(4'hF));
        #1 chk("midrst_d", d1, 0);
        chk("midrst_en", longint'(e1o), 0);
        step(0, 1, rep(4'h1), rep(4'h1));
        step(0, 0, '0, '0);
        #1 chk("killed_en", longint'(e1o), 0);
        step(0, 0, '0, '0);
        #1 chk("post_rst_en", longint'(e1o), 1);
        chk("post_rst_d", d1, 9);
        repeat (4) step(0, 0, '0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ce.md
CE -- requirements
Module: ce

Interface
REQ-001 The block SHALL have parameter CL_IN, default 4, number of input feature channels, range 3..64.
REQ-002 The block SHALL have parameter KERNEL, default 3, kernel side length, legal values 1, 3, 5 and 7.
REQ-003 The block SHALL have parameter RELU, default 1: 1 clamps negative results to 0; 0 passes signed results through.
REQ-004 The block SHALL have parameter N, default 4, data element width in bits.
REQ-005 The block SHALL have parameter M, default 4, weight element width in bits.
REQ-006 The block SHALL have parameter SR, default 2, arithmetic right-shift amount applied before output.
REQ-007 The block SHALL derive E = 3/4/5/1 for KERNEL = 3/5/7/other, and output width W = N+M+E+3.
REQ-008 The block SHALL have clk, input, 1, sole clock; all logic on its rising edge.
REQ-009 The block SHALL have rst, input, 1, reset; one clock; reset is synchronous and active-high.
REQ-010 The block SHALL have data2conv, input, CL_IN*KERNEL*KERNEL*N, packed signed data elements; element i is data2conv[i*N +: N].
REQ-011 The block SHALL have en_in, input, 1, input-valid qualifier for data2conv and w.
REQ-012 The block SHALL have w, input, CL_IN*KERNEL*KERNEL*M, packed signed weights; element i is w[i*M +: M].
REQ-013 The block SHALL have d_out, output, W, signed convolution result.
REQ-014 The block SHALL have en_out, output, 1, d_out valid strobe.

Function
REQ-015 Element index i SHALL be c*KERNEL*KERNEL + r*KERNEL + k (channel c, row r, column k); data element i SHALL pair only with weight element i.
REQ-016 All data and weight elements SHALL be two's-complement signed; each product SHALL be full precision, N+M bits.
REQ-017 The sum of all CL_IN*KERNEL*KERNEL products SHALL be formed at full precision, with no internal overflow for any input.
REQ-018 The sum SHALL be arithmetically shifted right by SR, rounding toward minus infinity.
REQ-019 With RELU=1, a negative shifted value SHALL become 0; with RELU=0 the value SHALL be unchanged.
REQ-020 The result SHALL saturate to the signed W-bit range [-2^(W-1), 2^(W-1)-1] before driving d_out.
REQ-021 The pipeline SHALL have 3 register stages: products; adder-tree sum; shift/ReLU/saturate into d_out.
REQ-022 Fixed latency SHALL be 3 cycles: inputs sampled with en_in=1 at edge t produce d_out and en_out=1 after edge t+3.
REQ-023 A valid bit SHALL travel with each stage; en_out SHALL equal en_in delayed by exactly 3 cycles.
REQ-024 Back-to-back en_in=1 SHALL give one result per cycle, in order, with no bubbles.
REQ-025 d_out SHALL update only when a valid result reaches the output stage; otherwise it SHALL hold its last value.
REQ-026 Invalid (en_in=0) samples SHALL NOT affect any later valid result.

Reset
REQ-027 While rst=1 at a rising edge, d_out SHALL become 0, en_out 0, and all stage valid bits 0.
REQ-028 Reset mid-operation SHALL discard all in-flight results; no en_out pulse SHALL appear for inputs sampled before or during reset.
REQ-029 Inputs with en_in=1 at the first edge after rst falls SHALL be processed normally, with 3-cycle latency.

Verification
REQ-030 Defaults, all data and weight bits 1 (every element -1), en_in=1 held -> after 3 cycles en_out=1 and d_out=9 every cycle (36 products of +1, >>2).
REQ-031 Defaults, data=+1 and weights=-1 everywhere -> d_out=0 with RELU=1; d_out=-9 with RELU=0.
REQ-032 Defaults, data=-8 and weights=-8 everywhere -> d_out=576 (36*64>>2), no saturation (W=14).
REQ-033 CL_IN=64, data=weights=-8 everywhere -> full sum 36864, >>2 = 9216 -> d_out saturates to 8191.
REQ-034 en_in pattern 1,0,1,1 with distinct inputs -> en_out shows 1,0,1,1 three cycles later, each d_out matching its own input.
REQ-035 rst asserted one cycle while two results are in flight -> en_out=0 and d_out=0 after that edge; neither result appears.
